// File: rtl/atm_keypad_encoder.sv
// atm_keypad_encoder: keypad front end for the ATM controller.
// Synchronises and debounces the raw key level, then turns each accepted press
// into either a PIN digit pulse or a decimal amount accumulation with ENTER strobe.
// Optional debounce stage: macro ATM_KEY_DEBOUNCE_EN (undefined -> IDLE goes
// straight to ACCEPT and DEBOUNCE_CYCLES has no effect).
module atm_keypad_encoder #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int MAX_MONTO_DIGITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_presionada,
    input  logic [3:0]  tecla_codigo,
    input  logic        modo_monto,
    output logic        add_digit,
    output logic [3:0]  digito,
    output logic        monto_stb,
    output logic [31:0] monto,
    output logic        desborde
);

    localparam int DCNT_W = $clog2(MAX_MONTO_DIGITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef ATM_KEY_DEBOUNCE_EN
        ST_DEBOUNCE = 2'd1,
`endif
        ST_ACCEPT   = 2'd2,
        ST_HELD     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic               modo_q;
    logic               mode_chg_s;
    logic [31:0]        acc_q, acc_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [31:0]        base_acc_s;
    logic [DCNT_W-1:0]  base_dcnt_s;
    logic [35:0]        next_s;
    logic               is_digit_s;
    logic               add_digit_q, add_digit_d;
    logic [3:0]         digito_q, digito_d;
    logic               monto_stb_q, monto_stb_d;
    logic [31:0]        monto_q, monto_d;
    logic               desborde_q, desborde_d;

`ifdef ATM_KEY_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    // Debounce length has no role when the debounce stage is compiled out.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

    // Two-flop synchroniser for the asynchronous key-down level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= tecla_presionada;
            s2_q <= s1_q;
        end
    end

    // Press-tracking FSM next state: one ACCEPT cycle per qualified press.
    always_comb begin
        state_d = state_q;
`ifdef ATM_KEY_DEBOUNCE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
`ifdef ATM_KEY_DEBOUNCE_EN
                    state_d = ST_DEBOUNCE;
                    cnt_d   = {CNT_W{1'b0}};
`else
                    state_d = ST_ACCEPT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ATM_KEY_DEBOUNCE_EN
            ST_DEBOUNCE: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_ACCEPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_ACCEPT: begin
                state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
`ifdef ATM_KEY_DEBOUNCE_EN
            cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
`ifdef ATM_KEY_DEBOUNCE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign mode_chg_s  = modo_monto ^ modo_q;
    assign is_digit_s  = (tecla_codigo <= 4'd9);
    // A mode change wipes the amount in progress, including for a key accepted in the same cycle.
    assign base_acc_s  = mode_chg_s ? 32'd0 : acc_q;
    assign base_dcnt_s = mode_chg_s ? {DCNT_W{1'b0}} : dcnt_q;
    assign next_s      = ({4'd0, base_acc_s} * 36'd10) + {32'd0, tecla_codigo};

    // Key action: PIN digit pulse, or amount accumulate / enter / clear.
    always_comb begin
        acc_d       = base_acc_s;
        dcnt_d      = base_dcnt_s;
        add_digit_d = 1'b0;
        digito_d    = digito_q;
        monto_stb_d = 1'b0;
        monto_d     = monto_q;
        desborde_d  = 1'b0;
        if (state_q == ST_ACCEPT) begin
            if (!modo_monto) begin
                if (is_digit_s) begin
                    digito_d    = tecla_codigo;
                    add_digit_d = 1'b1;
                end else begin
                    digito_d    = digito_q;
                end
            end else begin
                if (is_digit_s) begin
                    if ((next_s > 36'h0_FFFF_FFFF) ||
                        (base_dcnt_s == DCNT_W'(MAX_MONTO_DIGITS))) begin
                        desborde_d = 1'b1;
                    end else begin
                        acc_d  = next_s[31:0];
                        dcnt_d = base_dcnt_s + DCNT_W'(1);
                    end
                end else if (tecla_codigo == 4'hA) begin
                    if (base_dcnt_s != {DCNT_W{1'b0}}) begin
                        monto_d     = base_acc_s;
                        monto_stb_d = 1'b1;
                        acc_d       = 32'd0;
                        dcnt_d      = {DCNT_W{1'b0}};
                    end else begin
                        monto_stb_d = 1'b0;
                    end
                end else if (tecla_codigo == 4'hB) begin
                    acc_d  = 32'd0;
                    dcnt_d = {DCNT_W{1'b0}};
                end else begin
                    acc_d  = base_acc_s;
                end
            end
        end else begin
            add_digit_d = 1'b0;
        end
    end

    // Amount accumulator, digit count, mode history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            modo_q      <= 1'b0;
            acc_q       <= 32'd0;
            dcnt_q      <= {DCNT_W{1'b0}};
            add_digit_q <= 1'b0;
            digito_q    <= 4'd0;
            monto_stb_q <= 1'b0;
            monto_q     <= 32'd0;
            desborde_q  <= 1'b0;
        end else begin
            modo_q      <= modo_monto;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            add_digit_q <= add_digit_d;
            digito_q    <= digito_d;
            monto_stb_q <= monto_stb_d;
            monto_q     <= monto_d;
            desborde_q  <= desborde_d;
        end
    end

    assign add_digit = add_digit_q;
    assign digito    = digito_q;
    assign monto_stb = monto_stb_q;
    assign monto     = monto_q;
    assign desborde  = desborde_q;

endmodule

// File: tb/tb_atm_keypad_encoder.sv
// Testbench for atm_keypad_encoder: press-level model plus directed key sequences.
module tb_atm_keypad_encoder;

`ifdef ATM_KEY_DEBOUNCE_EN
    localparam int LAT         = 8;  // DEBOUNCE_CYCLES + 4
    localparam int EXP_BOUNCE  = 0;
`else
    localparam int LAT         = 4;
    localparam int EXP_BOUNCE  = 2;
`endif
    // Raw-high samples needed before an action is committed; its pulse lands 3 edges later.
    localparam int N_SMP = LAT - 3;

    logic        clk, rst, raw, modo;
    logic [3:0]  code;
    logic        add_digit, monto_stb, desborde;
    logic [3:0]  digito;
    logic [31:0] monto;

    atm_keypad_encoder dut (
        .clk(clk), .rst(rst), .tecla_presionada(raw), .tecla_codigo(code),
        .modo_monto(modo), .add_digit(add_digit), .digito(digito),
        .monto_stb(monto_stb), .monto(monto), .desborde(desborde)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_pass = 0;
    int edge_n = 0;
    int cnt_add = 0, cnt_stb = 0, cnt_des = 0, last_add_edge = -1;

    // model state
    logic        m_add, m_stb, m_des, m_prev;
    logic [3:0]  m_dig;
    logic [31:0] m_monto;
    longint      m_acc;
    int          m_cnt, run, fire;
    bit          armed;
    int          due_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic do_action();
        longint nxt;
        if (!modo) begin
            if (code <= 4'd9) begin m_dig = code; m_add = 1'b1; end
        end else if (code <= 4'd9) begin
            nxt = m_acc * 10 + longint'(code);
            if (nxt > 64'hFFFF_FFFF || m_cnt == 9) m_des = 1'b1;
            else begin m_acc = nxt; m_cnt++; end
        end else if (code == 4'hA) begin
            if (m_cnt > 0) begin m_monto = m_acc[31:0]; m_stb = 1'b1; m_acc = 0; m_cnt = 0; end
        end else if (code == 4'hB) begin
            m_acc = 0; m_cnt = 0;
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_add = 1'b0; m_stb = 1'b0; m_des = 1'b0; m_dig = 4'd0; m_monto = 32'd0;
            m_acc = 0; m_cnt = 0; m_prev = 1'b0; run = 0; armed = 1'b1; fire = -10;
            due_q.delete();
        end else begin
            m_add = 1'b0; m_stb = 1'b0; m_des = 1'b0;
            if (modo !== m_prev) begin m_acc = 0; m_cnt = 0; end
            m_prev = modo;
            if (due_q.size() > 0 && due_q[0] == edge_n) begin
                void'(due_q.pop_front());
                do_action();
            end
            if (raw) begin
                if (armed) begin
                    run++;
                    if (run == N_SMP) begin due_q.push_back(edge_n + 3); armed = 1'b0; fire = edge_n; end
                end
            end else begin
                run = 0;
                if (!armed && edge_n > fire + 1) armed = 1'b1;
            end
        end
    endtask

    // Per-cycle compare of every output against the model, plus pulse bookkeeping.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            model_step();
            #1;
            chk("add_digit", {31'd0, add_digit}, {31'd0, m_add});
            chk("digito",    {28'd0, digito},    {28'd0, m_dig});
            chk("monto_stb", {31'd0, monto_stb}, {31'd0, m_stb});
            chk("monto",     monto,              m_monto);
            chk("desborde",  {31'd0, desborde},  {31'd0, m_des});
            if (add_digit) begin cnt_add++; last_add_edge = edge_n; end
            if (monto_stb) cnt_stb++;
            if (desborde)  cnt_des++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        code = c; raw = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        raw = 1'b0;
        idle(8);
    endtask

    int e0, a0, p0;
    logic [3:0] digs [10];

    initial begin
        rst = 1'b0; raw = 1'b0; code = 4'd0; modo = 1'b0;
        idle(3);
        chk("reset_monto", monto, 32'd0);
        chk("reset_pulses", {29'd0, add_digit, monto_stb, desborde}, 32'd0);
        rst = 1'b1;
        idle(3);

        // 1: PIN key 7 held 20 cycles
        @(negedge clk);
        code = 4'h7; raw = 1'b1; e0 = edge_n; a0 = cnt_add;
        repeat (20) @(negedge clk);
        raw = 1'b0;
        idle(8);
        chk("pin_one_pulse", cnt_add - a0, 32'd1);
        chk("pin_digito", {28'd0, digito}, 32'd7);
        chk("pin_latency", last_add_edge - e0, LAT);

        // 2: bounce 1,1,0,1,1,0
        p0 = cnt_add + cnt_stb + cnt_des;
        code = 4'h3;
        raw = 1'b1; idle(2); raw = 1'b0; idle(1); raw = 1'b1; idle(2); raw = 1'b0;
        idle(10);
        chk("bounce_pulses", cnt_add + cnt_stb + cnt_des - p0, EXP_BOUNCE);

        // 3: amount 1250
        modo = 1'b1; idle(3);
        press(4'h1); press(4'h2); press(4'h5); press(4'h0);
        p0 = cnt_stb;
        press(4'hA);
        chk("amt_1250", monto, 32'd1250);
        chk("amt_stb", cnt_stb - p0, 32'd1);
        p0 = cnt_stb;
        press(4'hA);
        chk("empty_enter", cnt_stb - p0, 32'd0);

        // 4: ten digits, tenth overflows
        digs = '{4'h4, 4'h2, 4'h9, 4'h4, 4'h9, 4'h6, 4'h7, 4'h2, 4'h9, 4'h6};
        p0 = cnt_des;
        for (int i = 0; i < 10; i++) press(digs[i]);
        chk("ovf_desborde", cnt_des - p0, 32'd1);
        press(4'hA);
        chk("ovf_monto", monto, 32'd429496729);

        // 5: clear then 8
        press(4'h3); press(4'h3); press(4'hB); press(4'h8); press(4'hA);
        chk("clear_monto", monto, 32'd8);
        modo = 1'b0; idle(3);
        p0 = cnt_add + cnt_stb + cnt_des;
        press(4'hA);
        chk("pin_enter", cnt_add + cnt_stb + cnt_des - p0, 32'd0);

        // 6: reset while HELD with acc=55
        modo = 1'b1; idle(3);
        press(4'h5); press(4'h5);
        @(negedge clk);
        code = 4'hC; raw = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_monto", monto, 32'd0);
        chk("rst_digito", {28'd0, digito}, 32'd0);
        chk("rst_pulses", {29'd0, add_digit, monto_stb, desborde}, 32'd0);
        code = 4'h9; modo = 1'b0;
        idle(3);
        rst = 1'b1; e0 = edge_n; a0 = cnt_add;
        repeat (20) @(negedge clk);
        raw = 1'b0;
        idle(8);
        chk("rel_one_pulse", cnt_add - a0, 32'd1);
        chk("rel_latency", last_add_edge - e0, LAT);
        chk("rel_digito", {28'd0, digito}, 32'd9);
        modo = 1'b1; idle(3);
        press(4'h1); press(4'hA);
        chk("rst_acc_cleared", monto, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
